pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// - Owns the 8-bit program counter: sequential fetch, branch/jump/call/return redirects, stalls.
// - Resolves the branch condition from opcode/fcode and the ALU flags.
// - Keeps call return addresses in a hardware return-address stack (RAS); the single `ra` register is gone.
// - Sits between decode/ALU flags and instruction memory; drives the fetch address and the pipeline flush.
// PARAMETERS
// - RAS_DEPTH  4  RAS entries, power of 2, 2..16
// - RESET_PC   8'h00  PC value after reset
// PORTS
// - clk         in   1  clock; all state updates on rising edge
// - rst_n       in   1  synchronous reset, active-low
// - instr_valid in   1  decode slot holds a real instruction this cycle
// - opcode      in   3  decoded opcode; 3'b011 = jump, 3'b100 = branch class
// - fcode       in   4  branch function code: 0 b, 1 bz, 2 bnz, 3 bcy, 4 bncy, 5 bs, 6 bns, 7 bv, 8 bnv, 9 call, 10 return
// - lbl         in   8  branch target, absolute
// - cflag,zflag,oflag,sflag  in 1 each  ALU flags, valid in the same cycle as instr_valid
// - stall       in   1  hold PC; overrides everything except reset
// - pc          out  8  fetch address
// - flush       out  1  squash the instruction fetched in the previous cycle
// - ras_ovf     out  1  sticky: call issued while the RAS was full
// - ras_unf     out  1  sticky: return issued while the RAS was empty
// - halted      out  1  sequencer stopped after an underflow
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): pc=RESET_PC, flush=0, ras_ovf=0, ras_unf=0, halted=0, RAS empty. Applies mid-operation; any redirect in flight is lost.
// - FSM states: RUN, HALT. Reset goes to RUN. A return with an empty RAS moves RUN->HALT. HALT exits only by reset.
// - Resolved instruction = instr_valid & ~stall & state==RUN.
//   - taken = opcode==3'b011, or opcode==3'b100 with fcode 0, 9, 10, or with fcode 1..8 and its flag condition met.
//   - fcode 11..15, or any other opcode: not taken.
// - Next PC on a resolved instruction:
//   - jump/branch: lbl
//   - call: lbl, and push pc+1
//   - return: pop
//   - otherwise: pc+1
// - No resolved instruction: pc holds when stall=1 or HALT; otherwise pc+1.
// - Latency: a taken instruction sampled at edge N gives the new pc after edge N, and flush=1 for exactly the cycle after edge N.
// - flush is registered: 1 after a taken edge, otherwise 0. A stall edge clears it to 0.
// - Arithmetic: pc+1 is modulo 256 (8'hFF -> 8'h00). Pushed addresses are 8 bits.
// - RAS pointer wraps modulo RAS_DEPTH.
//   - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_ovf set.
//   - Pop when empty: pc holds, flush=0, ras_unf set, go to HALT.
// - Call and return never occur in the same cycle (one instruction per cycle).
// - Stall and taken in the same cycle: the instruction is not resolved; RAS and pc are unchanged.
// STRUCTURE
// - Shared package: OPC_JUMP=3'b011, OPC_BR=3'b100, FC_* constants 0..10, PC_W=8.
// - One sub-module: branch_ras.
//   - Ports: push, pop, din[7:0], dout[7:0], full, empty.
//   - Synchronous LIFO with a registered count; dout is the combinational top of stack.
// - Condition decode and next-PC mux live in pc_sequencer.
// TESTING
// - Reset, 4 free-running cycles -> pc 00,01,02,03; flush=0 throughout.
// - pc=05, opcode=011, lbl=40 -> pc=40 next cycle, flush=1 for 1 cycle, then 41.
// - bz with zflag=0 at pc=10 -> pc=11, no flush. bz with zflag=1, lbl=20 -> pc=20, flush=1.
// - call lbl=30 at pc=07, then return at pc=32 -> pc=30, then 31, 32, then 08; RAS empty afterwards.
// - RAS_DEPTH+1 nested calls -> ras_ovf=1; the following returns yield the newest RAS_DEPTH addresses only.
// - Return with empty RAS at pc=50 -> ras_unf=1, halted=1, pc stays 50; rst_n=0 -> pc=00, flags cleared.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared opcode/function codes, widths, states and branch condition decode.
package pc_sequencer_pkg;
    localparam int PC_W = 8;
    localparam logic [2:0] OPC_JUMP = 3'b011;
    localparam logic [2:0] OPC_BR = 3'b100;
    localparam logic [3:0] FC_B = 4'd0;
    localparam logic [3:0] FC_BZ = 4'd1;
    localparam logic [3:0] FC_BNZ = 4'd2;
    localparam logic [3:0] FC_BCY = 4'd3;
    localparam logic [3:0] FC_BNCY = 4'd4;
    localparam logic [3:0] FC_BS = 4'd5;
    localparam logic [3:0] FC_BNS = 4'd6;
    localparam logic [3:0] FC_BV = 4'd7;
    localparam logic [3:0] FC_BNV = 4'd8;
    localparam logic [3:0] FC_CALL = 4'd9;
    localparam logic [3:0] FC_RET = 4'd10;

    typedef enum logic {RUN, HALT} seq_state_e;

    function automatic logic br_cond(input logic [3:0] fc, input logic c, z, o, s);
        case (fc)
            FC_B, FC_CALL, FC_RET: return 1'b1;
            FC_BZ: return z;
            FC_BNZ: return ~z;
            FC_BCY: return c;
            FC_BNCY: return ~c;
            FC_BS: return s;
            FC_BNS: return ~s;
            FC_BV: return o;
            FC_BNV: return ~o;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/flag inputs and fetch-side outputs of the program counter sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;
    logic instr_valid;
    logic [2:0] opcode;
    logic [3:0] fcode;
    logic [PC_W-1:0] lbl;
    logic cflag, zflag, oflag, sflag;
    logic stall;
    logic [PC_W-1:0] pc;
    logic flush, ras_ovf, ras_unf, halted;

    modport master(
        output instr_valid, opcode, fcode, lbl, cflag, zflag, oflag, sflag, stall,
        input pc, flush, ras_ovf, ras_unf, halted
    );
    modport slave(
        input instr_valid, opcode, fcode, lbl, cflag, zflag, oflag, sflag, stall,
        output pc, flush, ras_ovf, ras_unf, halted
    );
endinterface

// File: rtl/pc_sequencer_branch_ras.sv
// branch_ras: return-address LIFO; a push when full silently overwrites the oldest entry.
module branch_ras import pc_sequencer_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);
    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, tp;
    logic [AW:0] cnt;

    // Circular write pointer: wrapping onto the oldest slot is what gives overwrite-on-full.
    assign tp = wp - AW'(1);
    assign dout = mem[tp];
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            cnt <= '0;
        end else if (push) begin
            mem[wp] <= din;
            wp <= wp + AW'(1);
            cnt <= full ? cnt : cnt + (AW+1)'(1);
        end else if (pop) begin
            wp <= tp;
            cnt <= cnt - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch resolution, return-address stack and halt on underflow.
module pc_sequencer import pc_sequencer_pkg::*; #(
    parameter int RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input logic clk,
    input logic rst_n,
    pc_sequencer_if.slave bus
);
    seq_state_e state, state_nx;
    logic [PC_W-1:0] pc_q, pc_nx, top;
    logic flush_q, ovf_q, unf_q;
    logic res, is_br, push, ret, pop, unf, taken, full, empty;

    branch_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .din(pc_q + PC_W'(1)), .dout(top), .full(full), .empty(empty)
    );

    always_comb begin
        res = bus.instr_valid & ~bus.stall & (state == RUN);
        is_br = res & (bus.opcode == OPC_BR);
        push = is_br & (bus.fcode == FC_CALL);
        ret = is_br & (bus.fcode == FC_RET);
        unf = ret & empty;
        pop = ret & ~empty;
        taken = (res & (bus.opcode == OPC_JUMP))
              | (is_br & br_cond(bus.fcode, bus.cflag, bus.zflag, bus.oflag, bus.sflag) & ~unf);
        // Underflowing return freezes pc; otherwise pc advances whenever running and not stalled.
        pc_nx = unf ? pc_q
              : pop ? top
              : taken ? bus.lbl
              : (state == RUN && !bus.stall) ? pc_q + PC_W'(1) : pc_q;
        state_nx = unf ? HALT : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            pc_q <= RESET_PC;
            flush_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q <= pc_nx;
            flush_q <= taken;
            ovf_q <= ovf_q | (push & full);
            unf_q <= unf_q | unf;
        end
    end

    assign bus.pc = pc_q;
    assign bus.flush = flush_q;
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
    assign bus.halted = state == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed literal checks plus randomized stimulus against a queue-based reference model.
module tb_pc_sequencer;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n;
    int n_tests = 0;
    int n_fail = 0;

    pc_sequencer_if b();
    pc_sequencer #(.RAS_DEPTH(D), .RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: pc arithmetic and a bounded queue standing in for the return stack.
    logic [7:0] m_pc;
    logic m_fl, m_ovf, m_unf, m_halt;
    logic [7:0] m_ras[$];

    always @(posedge clk) begin
        logic [7:0] nx;
        logic tk;
        if (!rst_n) begin
            m_pc = 8'h00; m_fl = 0; m_ovf = 0; m_unf = 0; m_halt = 0;
            m_ras.delete();
        end else begin
            nx = m_pc + 8'd1;
            tk = 0;
            if (b.instr_valid && !b.stall && !m_halt) begin
                if (b.opcode == 3'b011) tk = 1;
                else if (b.opcode == 3'b100)
                    case (b.fcode)
                        4'd0, 4'd9, 4'd10: tk = 1;
                        4'd1: tk = b.zflag;
                        4'd2: tk = !b.zflag;
                        4'd3: tk = b.cflag;
                        4'd4: tk = !b.cflag;
                        4'd5: tk = b.sflag;
                        4'd6: tk = !b.sflag;
                        4'd7: tk = b.oflag;
                        4'd8: tk = !b.oflag;
                        default: tk = 0;
                    endcase
                if (tk && b.opcode == 3'b100 && b.fcode == 4'd10) begin
                    if (m_ras.size() == 0) begin
                        m_unf = 1; m_halt = 1; nx = m_pc; tk = 0;
                    end else nx = m_ras.pop_back();
                end else if (tk) begin
                    if (b.opcode == 3'b100 && b.fcode == 4'd9) begin
                        if (m_ras.size() == D) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                        m_ras.push_back(m_pc + 8'd1);
                    end
                    nx = b.lbl;
                end
            end else if (b.stall || m_halt) nx = m_pc;
            m_pc = nx;
            m_fl = tk;
        end
        #1;
        check("model pc", b.pc, m_pc);
        check("model flush", 8'(b.flush), 8'(m_fl));
        check("model ras_ovf", 8'(b.ras_ovf), 8'(m_ovf));
        check("model ras_unf", 8'(b.ras_unf), 8'(m_unf));
        check("model halted", 8'(b.halted), 8'(m_halt));
    end

    task automatic drv(input logic v, input logic [2:0] op, input logic [3:0] fc,
                       input logic [7:0] l, input logic z, input logic st);
        b.instr_valid = v; b.opcode = op; b.fcode = fc; b.lbl = l;
        b.zflag = z; b.cflag = 0; b.oflag = 0; b.sflag = 0; b.stall = st;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(0, 3'b000, 4'd0, 8'h00, 0, 0);
    endtask

    task automatic call(input logic [7:0] l);
        drv(1, 3'b100, 4'd9, l, 0, 0);
    endtask

    task automatic ret();
        drv(1, 3'b100, 4'd10, 8'hEE, 0, 0);
    endtask

    task automatic jmp(input logic [7:0] l);
        drv(1, 3'b011, 4'd0, l, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        idle();
        idle();
        check("reset pc", b.pc, 8'h00);
        check("reset flush", 8'(b.flush), 8'h00);
        check("reset ovf", 8'(b.ras_ovf), 8'h00);
        check("reset unf", 8'(b.ras_unf), 8'h00);
        check("reset halted", 8'(b.halted), 8'h00);
        rst_n = 1;
        for (int i = 1; i < 4; i++) begin
            idle();
            check("free run pc", b.pc, 8'(i));
            check("free run flush", 8'(b.flush), 8'h00);
        end
        drv(1, 3'b011, 4'd0, 8'h77, 0, 1);
        check("stall jump pc", b.pc, 8'h03);
        check("stall jump flush", 8'(b.flush), 8'h00);
        idle();
        idle();
        check("pc before jump", b.pc, 8'h05);
        jmp(8'h40);
        check("jump pc", b.pc, 8'h40);
        check("jump flush", 8'(b.flush), 8'h01);
        idle();
        check("after jump pc", b.pc, 8'h41);
        check("after jump flush", 8'(b.flush), 8'h00);
        jmp(8'h10);
        drv(1, 3'b100, 4'd1, 8'h20, 0, 0);
        check("bz nt pc", b.pc, 8'h11);
        check("bz nt flush", 8'(b.flush), 8'h00);
        drv(1, 3'b100, 4'd1, 8'h20, 1, 0);
        check("bz t pc", b.pc, 8'h20);
        check("bz t flush", 8'(b.flush), 8'h01);
        jmp(8'h07);
        call(8'h30);
        check("call pc", b.pc, 8'h30);
        idle();
        idle();
        check("in sub pc", b.pc, 8'h32);
        ret();
        check("return pc", b.pc, 8'h08);
        check("return flush", 8'(b.flush), 8'h01);
        call(8'h60);
        call(8'h70);
        call(8'h80);
        call(8'h90);
        check("no ovf yet", 8'(b.ras_ovf), 8'h00);
        call(8'hA0);
        check("ovf call pc", b.pc, 8'hA0);
        check("ovf set", 8'(b.ras_ovf), 8'h01);
        ret();
        check("ret1", b.pc, 8'h91);
        ret();
        check("ret2", b.pc, 8'h81);
        ret();
        check("ret3", b.pc, 8'h71);
        ret();
        check("ret4", b.pc, 8'h61);
        check("no unf yet", 8'(b.ras_unf), 8'h00);
        jmp(8'h50);
        ret();
        check("unf pc", b.pc, 8'h50);
        check("unf flush", 8'(b.flush), 8'h00);
        check("unf set", 8'(b.ras_unf), 8'h01);
        check("halted set", 8'(b.halted), 8'h01);
        jmp(8'h99);
        check("halted pc", b.pc, 8'h50);
        rst_n = 0;
        idle();
        check("rereset pc", b.pc, 8'h00);
        check("rereset ovf", 8'(b.ras_ovf), 8'h00);
        check("rereset unf", 8'(b.ras_unf), 8'h00);
        check("rereset halted", 8'(b.halted), 8'h00);
        rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = !((m_halt && $urandom_range(3) == 0) || $urandom_range(199) == 0);
            b.instr_valid = $urandom_range(3) != 0;
            r = $urandom_range(9);
            b.opcode = r < 6 ? 3'b100 : r < 7 ? 3'b011 : 3'($urandom_range(7));
            b.fcode = $urandom_range(2) == 0 ? ($urandom_range(1) ? 4'd9 : 4'd10) : 4'($urandom_range(15));
            b.lbl = 8'($urandom_range(255));
            b.cflag = 1'($urandom_range(1));
            b.zflag = 1'($urandom_range(1));
            b.oflag = 1'($urandom_range(1));
            b.sflag = 1'($urandom_range(1));
            b.stall = $urandom_range(7) == 0;
            @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
